// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the frame buffer write path: default raster size,
// SRAM address layout, the write-sequencer state encoding and the layout of
// one buffered write entry.
// ---------------------------------------------------------------------------
package fb_pkg;

    localparam int H_RES_DEFAULT      = 640;
    localparam int V_RES_DEFAULT      = 480;
    localparam int FIFO_DEPTH_DEFAULT = 8;

    localparam int FRAME_OFS_W = 19;               // pixel offset inside one frame
    localparam int SRAM_ADDR_W = 20;               // {frame_bit, offset}
    localparam int DATA_W      = 16;
    localparam int ENTRY_W     = 1 + FRAME_OFS_W + DATA_W;   // 36

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2
    } wr_state_e;

    // One buffered write. frame_bit is frozen when the strobe is accepted so
    // a later flip does not retarget words already queued.
    typedef struct packed {
        logic                   frame_bit;
        logic [FRAME_OFS_W-1:0] offset;
        logic [DATA_W-1:0]      data;
    } fb_entry_t;

    function automatic logic [SRAM_ADDR_W-1:0] entry_addr(input fb_entry_t e);
        return {e.frame_bit, e.offset};
    endfunction

endpackage

// File: rtl/fb_write_fifo.sv
// ---------------------------------------------------------------------------
// fb_write_fifo
// Synchronous show-ahead FIFO buffering SRAM writes.
//   clk, reset        : clock, synchronous active-high reset (empties FIFO)
//   push, push_data   : write request and entry
//   pop               : remove head (ignored when empty)
//   head, second      : oldest and second-oldest entries (valid per count)
//   count, empty      : occupancy
//   push_accept       : push taken this cycle
//   push_drop         : push refused because FIFO full and no pop
// A pop in the same cycle as a push to a full FIFO frees the slot first, so
// the push is accepted. DEPTH must be a power of two, >= 2.
// ---------------------------------------------------------------------------
module fb_write_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 36,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] second,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             push_accept,
    output logic             push_drop
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             full_s;
    logic             pop_ok_s;
    logic             push_ok_s;
    logic [AW-1:0]    rd_next_s;

    // Flag and handshake decode.
    always_comb begin
        empty       = (count_r == '0);
        full_s      = (count_r == CW'(DEPTH));
        pop_ok_s    = pop && !empty;
        push_ok_s   = push && (!full_s || pop_ok_s);
        push_accept = push_ok_s;
        push_drop   = push && !push_ok_s;
        rd_next_s   = rd_ptr_r + AW'(1'b1);
        head        = mem_r[rd_ptr_r];
        second      = mem_r[rd_next_s];
        count       = count_r;
    end

    // Storage array; contents need no reset since reads are qualified by count.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_next_s;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/frame_buffer_writer.sv
// ---------------------------------------------------------------------------
// frame_buffer_writer
// Accepts (x, y, data) pixel writes from the copy engine, maps them into the
// back frame of a double-buffered SRAM, buffers them and writes them out
// whenever the shared SRAM port is granted. Also owns the front-frame bit and
// the palette selection, both updated on flip_req.
//
// Ports
//   Clk, Reset                 : clock, synchronous active-high reset
//   program_x/_y/_data/_write  : pixel write strobe (no back-pressure)
//   palette_index, flip_req    : palette for next front frame, flip pulse
//   current_frame, palette_sel : displayed frame and its palette
//   sram_req, sram_gnt         : port request / arbiter grant
//   sram_addr, sram_wdata,
//   sram_we_n                  : SRAM write cycle (addr = {frame, offset})
//   overflow                   : sticky, a write was lost to a full buffer
//
// Optional build macro FB_WRITER_STATS_EN adds stat_writes[15:0] (SRAM
// writes issued) and stat_drops[15:0] (range + overflow drops), both wrap.
// ---------------------------------------------------------------------------
module frame_buffer_writer
    import fb_pkg::*;
#(
    parameter int H_RES      = H_RES_DEFAULT,
    parameter int V_RES      = V_RES_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [9:0]             program_x,
    input  logic [9:0]             program_y,
    input  logic                   program_write,
    input  logic [DATA_W-1:0]      program_data,
    input  logic [1:0]             palette_index,
    input  logic                   flip_req,
    output logic                   current_frame,
    output logic [1:0]             palette_sel,
    output logic                   sram_req,
    input  logic                   sram_gnt,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0]      sram_wdata,
    output logic                   sram_we_n,
    output logic                   overflow
`ifdef FB_WRITER_STATS_EN
    ,
    output logic [15:0]            stat_writes,
    output logic [15:0]            stat_drops
`endif
);

    localparam int                     CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1'b1);
    localparam logic [9:0]             H_LIMIT   = 10'(H_RES);
    localparam logic [9:0]             V_LIMIT   = 10'(V_RES);
    localparam logic [FRAME_OFS_W-1:0] H_RES_OFS = FRAME_OFS_W'(H_RES);

    // Line-major offset; the default 640-wide raster is 512 + 128 words.
    function automatic logic [FRAME_OFS_W-1:0] pixel_offset(input logic [9:0] x,
                                                           input logic [9:0] y);
        logic [FRAME_OFS_W-1:0] x_w;
        logic [FRAME_OFS_W-1:0] y_w;
        x_w = {9'd0, x};
        y_w = {9'd0, y};
        if (H_RES == 640) begin
            return (y_w << 4'd9) + (y_w << 4'd7) + x_w;
        end else begin
            return (y_w * H_RES_OFS) + x_w;
        end
    endfunction

    logic             current_frame_r;
    logic [1:0]       palette_sel_r;
    logic             overflow_r;
    logic             in_range_s;
    fb_entry_t        strobe_entry_s;
    logic             s1_valid_r;
    fb_entry_t        s1_entry_r;

    logic [ENTRY_W-1:0] head_s;
    logic [ENTRY_W-1:0] second_s;
    fb_entry_t        head_e;
    fb_entry_t        second_e;
    logic [CNT_W-1:0] count_s;
    logic             empty_s;
    logic             push_accept_s;
    logic             push_drop_s;
    logic             pop_s;

    wr_state_e        state_r;
    logic             sram_req_r;
    logic             sram_we_n_r;
    logic [SRAM_ADDR_W-1:0] sram_addr_r;
    logic [DATA_W-1:0] sram_wdata_r;
    logic             more_s;
    fb_entry_t        next_head_s;

    // Stage 1: range check and address mapping in the strobe cycle.
    always_comb begin
        in_range_s               = (program_x < H_LIMIT) && (program_y < V_LIMIT);
        strobe_entry_s.frame_bit = ~current_frame_r;
        strobe_entry_s.offset    = pixel_offset(program_x, program_y);
        strobe_entry_s.data      = program_data;
    end

    // Stage 1 register; out-of-range strobes simply never become valid.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_r <= 1'b0;
            s1_entry_r <= '0;
        end else begin
            s1_valid_r <= program_write && in_range_s;
            s1_entry_r <= strobe_entry_s;
        end
    end

    // Stage 2: the FIFO push happens one cycle after the strobe.
    fb_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (Clk),
        .reset       (Reset),
        .push        (s1_valid_r),
        .push_data   (s1_entry_r),
        .pop         (pop_s),
        .head        (head_s),
        .second      (second_s),
        .count       (count_s),
        .empty       (empty_s),
        .push_accept (push_accept_s),
        .push_drop   (push_drop_s)
    );

    assign head_e   = head_s;
    assign second_e = second_s;
    assign pop_s    = (state_r == ST_WRITE);

    // Look-ahead: what the FIFO head becomes after this cycle's pop, so the
    // registered address/data can be ready for a back-to-back write.
    always_comb begin
        more_s      = 1'b0;
        next_head_s = head_e;
        if (state_r == ST_WRITE) begin
            if (count_s > CNT_ONE) begin
                more_s      = 1'b1;
                next_head_s = second_e;
            end else if (push_accept_s) begin
                more_s      = 1'b1;
                next_head_s = s1_entry_r;
            end else begin
                more_s      = 1'b0;
                next_head_s = head_e;
            end
        end else begin
            more_s      = 1'b0;
            next_head_s = head_e;
        end
    end

    // SRAM write sequencer with registered port outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= ST_IDLE;
            sram_req_r   <= 1'b0;
            sram_we_n_r  <= 1'b1;
            sram_addr_r  <= '0;
            sram_wdata_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sram_we_n_r <= 1'b1;
                    if (!empty_s) begin
                        state_r      <= ST_REQ;
                        sram_req_r   <= 1'b1;
                        sram_addr_r  <= entry_addr(head_e);
                        sram_wdata_r <= head_e.data;
                    end else begin
                        sram_req_r   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    // Head is stable here: nothing pops outside WRITE.
                    sram_req_r <= 1'b1;
                    if (sram_gnt) begin
                        state_r     <= ST_WRITE;
                        sram_we_n_r <= 1'b0;
                    end else begin
                        sram_we_n_r <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (more_s) begin
                        sram_addr_r  <= entry_addr(next_head_s);
                        sram_wdata_r <= next_head_s.data;
                        if (sram_gnt) begin
                            state_r     <= ST_WRITE;
                            sram_we_n_r <= 1'b0;
                        end else begin
                            state_r     <= ST_REQ;
                            sram_we_n_r <= 1'b1;
                        end
                    end else begin
                        state_r     <= ST_IDLE;
                        sram_req_r  <= 1'b0;
                        sram_we_n_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    sram_req_r  <= 1'b0;
                    sram_we_n_r <= 1'b1;
                end
            endcase
        end
    end

    // Front-frame and palette swap on the flip pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            current_frame_r <= 1'b0;
            palette_sel_r   <= 2'd0;
        end else if (flip_req) begin
            current_frame_r <= ~current_frame_r;
            palette_sel_r   <= palette_index;
        end else begin
            current_frame_r <= current_frame_r;
            palette_sel_r   <= palette_sel_r;
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r | push_drop_s;
        end
    end

    assign current_frame = current_frame_r;
    assign palette_sel   = palette_sel_r;
    assign sram_req      = sram_req_r;
    assign sram_addr     = sram_addr_r;
    assign sram_wdata    = sram_wdata_r;
    assign sram_we_n     = sram_we_n_r;
    assign overflow      = overflow_r;

`ifdef FB_WRITER_STATS_EN
    logic [15:0] stat_writes_r;
    logic [15:0] stat_drops_r;
    logic        range_drop_s;

    // A strobe outside the raster is a drop.
    always_comb begin
        range_drop_s = program_write && !in_range_s;
    end

    // Wrapping write and drop counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stat_writes_r <= 16'd0;
            stat_drops_r  <= 16'd0;
        end else begin
            stat_writes_r <= stat_writes_r + {15'd0, (state_r == ST_WRITE)};
            stat_drops_r  <= stat_drops_r + {15'd0, range_drop_s} + {15'd0, push_drop_s};
        end
    end

    assign stat_writes = stat_writes_r;
    assign stat_drops  = stat_drops_r;
`endif

endmodule
